gba_eeprom_host: RTL and testbench
==================================

Name: gba_eeprom_host

Overview:
- Initiator side of the GBA cartridge serial EEPROM protocol, i.e. the role the DMA3 engine plays against the EEPROM responder.
- Accepts one block-level request at a time:
  - read: one 64-bit block;
  - write: one 64-bit block.
- Serialises the request into single-bit transfers on the 1-bit EEPROM bus and returns the read data.
- For a write, polls until the device reports ready.
- Used by the save-backup/test path, and drives the DMA-count hint the responder uses for model detection.

Parameters:
- POLL_TIMEOUT, 20'd100000, max ready-poll reads after a write before aborting with error.
- BIT_GAP, 2, idle cycles inserted between consecutive bit transfers (0 = back-to-back).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- model  in  1  address length: 0 = 6-bit (512 B), 1 = 14-bit (8 KB); sampled at request accept.
- req_valid  in  1  request present.
- req_ready  out  1  host idle, can accept a request.
- req_write  in  1  1 = write block, 0 = read block.
- req_addr  in  14  block address; only the low 6 bits are used when model = 0.
- req_wdata  in  64  write data; bit 63 is sent first.
- resp_valid  out  1  one-cycle pulse: request finished.
- resp_error  out  1  qualified by resp_valid: write poll timed out.
- resp_rdata  out  64  read data; bit 63 is the first data bit received. Held until the next read completes.
- ee_cs  out  1  EEPROM chip select, high while busy.
- ee_valid  out  1  bit transfer request.
- ee_write  out  1  1 = host drives bit, 0 = host reads bit.
- ee_ready  in  1  transfer accepted in the same cycle.
- ee_dout  out  1  bit to EEPROM (valid when ee_write = 1).
- ee_din  in  1  bit from EEPROM (sampled on a read handshake).
- dma_eepromcount  out  17  transfer length hint for the current command, 0 when idle.

Behaviour:

Reset:
- Outputs: req_ready = 1, resp_valid = 0, resp_error = 0, resp_rdata = 0, ee_cs = ee_valid = ee_write = ee_dout = 0, dma_eepromcount = 0.
- State goes to IDLE.
- Reset mid-transaction abandons it immediately, with no resp_valid.

Handshakes:
- Request accept happens on req_valid & req_ready.
  - Latch write, addr, wdata and model (n = 6 or 14).
  - req_ready drops the next cycle.
- Bit transfer completes on ee_valid & ee_ready.
  - Host holds ee_valid, ee_write and ee_dout stable until the handshake completes.
  - After each handshake, ee_valid is low for BIT_GAP cycles, then reasserts with the next bit.
  - Read bits are captured from ee_din in the handshake cycle.

dma_eepromcount, set at accept and held until IDLE:

| Command | model = 0 | model = 1 |
|---|---|---|
| read | 9 | 17 |
| write | 73 | 81 |

State machine (ee_cs = 1 in all states except IDLE):
- IDLE: on accept -> CMD.
- CMD: two writes, "1" then "0" for a write, "1" then "1" for a read -> ADDR.
- ADDR: n writes, address MSB first (bit n-1 down to bit 0).
  - Write -> WDATA.
  - Read -> RSTOP.
- WDATA: 64 writes, bit 63 down to bit 0 -> WSTOP.
- WSTOP / RSTOP: one write of "0".
  - WSTOP -> POLL.
  - RSTOP -> RHEAD.
- RHEAD: 4 reads, discarded -> RDATA.
- RDATA: 64 reads, shifted in MSB first. After the 64th, update resp_rdata, pulse resp_valid with resp_error = 0 -> IDLE.
- POLL: repeated reads.
  - A read returning 1 -> resp_valid, resp_error = 0 -> IDLE.
  - Otherwise increment the poll counter. When the counter reaches POLL_TIMEOUT -> resp_valid, resp_error = 1 -> IDLE.
- Totals:
  - write = 2 + n + 64 + 1 write transfers, plus at least 1 poll read;
  - read = 2 + n + 1 write transfers, plus 68 read transfers.

Timing and boundaries:
- Leaving IDLE: ee_cs, dma_eepromcount and req_ready change the cycle after accept. The first ee_valid asserts that same cycle, with no BIT_GAP before the first bit.
- On return to IDLE: ee_cs = 0, ee_valid = 0, dma_eepromcount = 0, req_ready = 1 in the same cycle as resp_valid. A new request can be accepted in that cycle.
- Read failure: resp_error is never set on reads; a read has no failure path.
- Bit counters: 7-bit, compared exactly; there is no wrap.
- Poll counter: 20-bit, cleared on entering POLL.
- model = 0 addressing: req_addr[13:6] is ignored; exactly 6 address bits are sent.
- ee_ready held low: the host waits indefinitely in any non-POLL state. A POLL read that never handshakes does not advance the timeout.

Test Plan:
- BIT_GAP = 0, model = 0, write addr 6'h2A, data 64'h0123_4567_89AB_CDEF, responder always ready and returning 1 on polls -> serial write stream "10" + "101010" + data MSB-first + "0" (73 bits); dma_eepromcount = 73 while busy; resp_valid with resp_error = 0 after 1 poll.
- model = 0, read addr 6'h2A after the above write -> 9 writes "11" "101010" "0", then 68 reads; resp_rdata = 64'h0123_4567_89AB_CDEF; dma_eepromcount = 9.
- model = 1, write then read addr 14'h3FFF, data 64'hFFFF_0000_A5A5_5A5A -> 81-bit and 17-bit command streams with 14 address bits all 1; data round-trips.
- Responder returns 0 on POLL forever, POLL_TIMEOUT = 16 -> exactly 16 poll reads, then resp_valid with resp_error = 1; req_ready = 1 in the same cycle.
- BIT_GAP = 2, ee_ready randomly stalled -> exactly 2 low cycles between each handshake and the next ee_valid; ee_dout stable through stalls; same data as the stall-free run.
- rst asserted at bit 40 of WDATA -> next cycle all outputs at reset values, no resp_valid; a following read request completes normally.

Source files
------------

// File: rtl/gba_eeprom_host.sv
// Initiator for the GBA cartridge serial EEPROM protocol.
// One 64-bit block read or write is serialised into single-bit transfers,
// with ready polling after writes and a DMA-length hint for the responder.
module gba_eeprom_host #(
    parameter logic [19:0] POLL_TIMEOUT = 20'd100000,
    parameter int          BIT_GAP      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        model,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [13:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [63:0] resp_rdata,
    output logic        ee_cs,
    output logic        ee_valid,
    output logic        ee_write,
    input  logic        ee_ready,
    output logic        ee_dout,
    input  logic        ee_din,
    output logic [16:0] dma_eepromcount
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_WSTOP,
        S_RSTOP,
        S_RHEAD,
        S_RDATA,
        S_POLL
    } state_t;

    localparam logic [7:0] GAP = 8'(BIT_GAP);

    state_t      state;
    logic        is_write;
    logic [13:0] addr_sh;     // address left-aligned so bit 13 is always the next to send
    logic [6:0]  addr_last;   // index of the final address bit (n-1)
    logic [63:0] wdata_sh;
    logic [63:0] rdata_sh;
    logic [6:0]  bit_cnt;
    logic [7:0]  gap_cnt;
    logic [19:0] poll_cnt;

    logic        hs;
    logic [19:0] poll_inc;

    assign hs       = ee_valid & ee_ready;
    assign poll_inc = poll_cnt + 20'd1;

    // Protocol sequencer: on each handshake prepare the next bit, then hold it
    // off the bus for the inter-bit gap before raising ee_valid again.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            is_write        <= 1'b0;
            addr_sh         <= '0;
            addr_last       <= '0;
            wdata_sh        <= '0;
            rdata_sh        <= '0;
            bit_cnt         <= '0;
            gap_cnt         <= '0;
            poll_cnt        <= '0;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_error      <= 1'b0;
            resp_rdata      <= '0;
            ee_cs           <= 1'b0;
            ee_valid        <= 1'b0;
            ee_write        <= 1'b0;
            ee_dout         <= 1'b0;
            dma_eepromcount <= '0;
        end else begin
            resp_valid <= 1'b0;

            // Inter-bit gap countdown; the last gap cycle re-raises ee_valid.
            if (state != S_IDLE && !ee_valid && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
                if (gap_cnt == 8'd1) begin
                    ee_valid <= 1'b1;
                end
            end

            // Every completed bit is followed by the gap (or none if GAP is 0).
            if (hs) begin
                ee_valid <= (GAP == 8'd0);
                gap_cnt  <= GAP;
            end

            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        is_write        <= req_write;
                        addr_sh         <= model ? req_addr : {req_addr[5:0], 8'd0};
                        addr_last       <= model ? 7'd13 : 7'd5;
                        wdata_sh        <= req_wdata;
                        dma_eepromcount <= req_write ? (model ? 17'd81 : 17'd73)
                                                     : (model ? 17'd17 : 17'd9);
                        state           <= S_CMD;
                        req_ready       <= 1'b0;
                        ee_cs           <= 1'b1;
                        ee_valid        <= 1'b1;
                        ee_write        <= 1'b1;
                        ee_dout         <= 1'b1;
                        bit_cnt         <= '0;
                        gap_cnt         <= '0;
                    end
                end

                S_CMD: begin
                    if (hs) begin
                        if (bit_cnt == 7'd0) begin
                            bit_cnt <= 7'd1;
                            ee_dout <= ~is_write;
                        end else begin
                            bit_cnt <= '0;
                            state   <= S_ADDR;
                            ee_dout <= addr_sh[13];
                        end
                    end
                end

                S_ADDR: begin
                    if (hs) begin
                        if (bit_cnt == addr_last) begin
                            bit_cnt <= '0;
                            if (is_write) begin
                                state   <= S_WDATA;
                                ee_dout <= wdata_sh[63];
                            end else begin
                                state   <= S_RSTOP;
                                ee_dout <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 7'd1;
                            ee_dout <= addr_sh[12];
                            addr_sh <= {addr_sh[12:0], 1'b0};
                        end
                    end
                end

                S_WDATA: begin
                    if (hs) begin
                        if (bit_cnt == 7'd63) begin
                            bit_cnt <= '0;
                            state   <= S_WSTOP;
                            ee_dout <= 1'b0;
                        end else begin
                            bit_cnt  <= bit_cnt + 7'd1;
                            ee_dout  <= wdata_sh[62];
                            wdata_sh <= {wdata_sh[62:0], 1'b0};
                        end
                    end
                end

                S_WSTOP: begin
                    if (hs) begin
                        state    <= S_POLL;
                        ee_write <= 1'b0;
                        ee_dout  <= 1'b0;
                        poll_cnt <= '0;
                    end
                end

                S_RSTOP: begin
                    if (hs) begin
                        state    <= S_RHEAD;
                        ee_write <= 1'b0;
                        ee_dout  <= 1'b0;
                        bit_cnt  <= '0;
                    end
                end

                S_RHEAD: begin
                    if (hs) begin
                        if (bit_cnt == 7'd3) begin
                            bit_cnt <= '0;
                            state   <= S_RDATA;
                        end else begin
                            bit_cnt <= bit_cnt + 7'd1;
                        end
                    end
                end

                S_RDATA: begin
                    if (hs) begin
                        rdata_sh <= {rdata_sh[62:0], ee_din};
                        if (bit_cnt == 7'd63) begin
                            resp_rdata      <= {rdata_sh[62:0], ee_din};
                            resp_error      <= 1'b0;
                            resp_valid      <= 1'b1;
                            state           <= S_IDLE;
                            req_ready       <= 1'b1;
                            ee_cs           <= 1'b0;
                            ee_valid        <= 1'b0;
                            ee_write        <= 1'b0;
                            ee_dout         <= 1'b0;
                            dma_eepromcount <= '0;
                            gap_cnt         <= '0;
                            bit_cnt         <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 7'd1;
                        end
                    end
                end

                S_POLL: begin
                    if (hs) begin
                        if (ee_din || poll_inc == POLL_TIMEOUT) begin
                            resp_error      <= ~ee_din;
                            resp_valid      <= 1'b1;
                            state           <= S_IDLE;
                            req_ready       <= 1'b1;
                            ee_cs           <= 1'b0;
                            ee_valid        <= 1'b0;
                            ee_write        <= 1'b0;
                            ee_dout         <= 1'b0;
                            dma_eepromcount <= '0;
                            gap_cnt         <= '0;
                        end else begin
                            poll_cnt <= poll_inc;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gba_eeprom_host.sv
// Directed bench for gba_eeprom_host: a table of block requests run against
// a bit-level responder, plus hand-written reset and idle sequences.
module tb_gba_eeprom_host;

    localparam int          GAP = 2;
    localparam logic [19:0] TMO = 20'd16;

    localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D2 = 64'hFFFF_0000_A5A5_5A5A;
    localparam logic [63:0] D3 = 64'hDEAD_BEEF_0F0F_F0F0;
    localparam logic [63:0] D4 = 64'h8000_0000_0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        model = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [13:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_error;
    logic [63:0] resp_rdata;
    logic        ee_cs;
    logic        ee_valid;
    logic        ee_write;
    logic        ee_ready = 1'b0;
    logic        ee_dout;
    logic        ee_din = 1'b0;
    logic [16:0] dma_eepromcount;

    gba_eeprom_host #(
        .POLL_TIMEOUT(TMO),
        .BIT_GAP     (GAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .model          (model),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_error     (resp_error),
        .resp_rdata     (resp_rdata),
        .ee_cs          (ee_cs),
        .ee_valid       (ee_valid),
        .ee_write       (ee_write),
        .ee_ready       (ee_ready),
        .ee_dout        (ee_dout),
        .ee_din         (ee_din),
        .dma_eepromcount(dma_eepromcount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Responder configuration, set per transaction
    logic        stall = 1'b0;
    logic        cur_write = 1'b0;
    int          poll_zeros = 0;
    logic [63:0] rd_data = '0;

    // Responder observations
    int           wcount = 0;
    int           rcount = 0;
    int           low_cnt = 0;
    logic [127:0] wstream = '0;
    logic         hs_any = 1'b0;
    logic         prev_pending = 1'b0;
    logic         prev_write = 1'b0;
    logic         prev_dout = 1'b0;
    logic         prev_valid = 1'b0;
    logic         prev_cs = 1'b0;

    // Bit-level responder: drives ee_ready/ee_din for the coming edge,
    // records each handshake and checks gap and hold behaviour.
    always @(negedge clk) begin
        logic [5:0] bi;
        if (ee_cs && !prev_cs) begin
            wcount  = 0;
            rcount  = 0;
            wstream = '0;
            low_cnt = 0;
            hs_any  = 1'b0;
        end
        if (prev_pending && ee_cs)
            check("ee hold through stall", 128'({ee_valid, ee_write, ee_dout}),
                  128'({1'b1, prev_write, prev_dout}));
        if (ee_cs && ee_valid && !prev_valid && hs_any)
            check("bit gap low cycles", 128'(low_cnt), 128'(GAP));
        if (ee_cs && !ee_valid) low_cnt++;

        ee_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cur_write) begin
            ee_din = (rcount >= poll_zeros);
        end else if (rcount < 4 || rcount > 67) begin
            ee_din = 1'b1;
        end else begin
            bi     = 6'(67 - rcount);
            ee_din = rd_data[bi];
        end

        if (ee_valid && ee_ready) begin
            if (ee_write) begin
                wstream = {wstream[126:0], ee_dout};
                wcount++;
            end else begin
                rcount++;
            end
            low_cnt = 0;
            hs_any  = 1'b1;
        end
        prev_pending = ee_valid && !ee_ready;
        prev_write   = ee_write;
        prev_dout    = ee_dout;
        prev_valid   = ee_valid;
        prev_cs      = ee_cs;
    end

    typedef struct {
        logic         wr;
        logic         mdl;
        logic [13:0]  addr;
        logic [63:0]  wdata;
        logic         stl;
        int           pz;
        logic [63:0]  rd;
        logic [16:0]  exp_cnt;
        int           exp_wbits;
        logic [127:0] exp_stream;
        int           exp_reads;
        logic         exp_err;
        logic [63:0]  exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int idx, input vec_t v);
        logic got;
        logic dma_bad;
        @(negedge clk);
        stall      = v.stl;
        cur_write  = v.wr;
        poll_zeros = v.pz;
        rd_data    = v.rd;
        check($sformatf("v%0d req_ready before", idx), 128'(req_ready), 128'(1'b1));
        req_valid = 1'b1;
        req_write = v.wr;
        model     = v.mdl;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        model     = ~v.mdl;
        check($sformatf("v%0d first bit cs/valid/write/dout/ready", idx),
              128'({ee_cs, ee_valid, ee_write, ee_dout, req_ready}), 128'(5'b11110));
        check($sformatf("v%0d dma_eepromcount", idx), 128'(dma_eepromcount), 128'(v.exp_cnt));
        got     = 1'b0;
        dma_bad = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            if (dma_eepromcount != v.exp_cnt || !ee_cs) dma_bad = 1'b1;
        end
        check($sformatf("v%0d resp_valid within budget", idx), 128'(got), 128'(1'b1));
        if (got) begin
            check($sformatf("v%0d resp_error", idx), 128'(resp_error), 128'(v.exp_err));
            check($sformatf("v%0d idle at resp ready/cs/valid", idx),
                  128'({req_ready, ee_cs, ee_valid}), 128'(3'b100));
            check($sformatf("v%0d dma zero at resp", idx), 128'(dma_eepromcount), 128'(0));
            check($sformatf("v%0d dma/cs steady while busy", idx), 128'(dma_bad), 128'(1'b0));
            check($sformatf("v%0d write bit count", idx), 128'(wcount), 128'(v.exp_wbits));
            check($sformatf("v%0d write stream", idx), wstream, v.exp_stream);
            check($sformatf("v%0d read transfers", idx), 128'(rcount), 128'(v.exp_reads));
            check($sformatf("v%0d resp_rdata", idx), 128'(resp_rdata), 128'(v.exp_rdata));
            @(negedge clk);
            check($sformatf("v%0d resp_valid one cycle", idx), 128'(resp_valid), 128'(1'b0));
        end
    endtask

    initial begin
        logic seen;
        logic reached;

        vecs[0] = '{1'b1, 1'b0, 14'h002A, D1, 1'b0, 0, 64'h0, 17'd73, 73,
                    128'({2'b10, 6'h2A, D1, 1'b0}), 1, 1'b0, 64'h0};
        vecs[1] = '{1'b0, 1'b0, 14'h3FEA, 64'h0, 1'b0, 0, D1, 17'd9, 9,
                    128'({2'b11, 6'h2A, 1'b0}), 68, 1'b0, D1};
        vecs[2] = '{1'b1, 1'b1, 14'h3FFF, D2, 1'b0, 0, 64'h0, 17'd81, 81,
                    128'({2'b10, 14'h3FFF, D2, 1'b0}), 1, 1'b0, D1};
        vecs[3] = '{1'b0, 1'b1, 14'h3FFF, 64'h0, 1'b0, 0, D2, 17'd17, 17,
                    128'({2'b11, 14'h3FFF, 1'b0}), 68, 1'b0, D2};
        vecs[4] = '{1'b1, 1'b0, 14'h002A, D1, 1'b1, 3, 64'h0, 17'd73, 73,
                    128'({2'b10, 6'h2A, D1, 1'b0}), 4, 1'b0, D2};
        vecs[5] = '{1'b0, 1'b0, 14'h002A, 64'h0, 1'b1, 0, D1, 17'd9, 9,
                    128'({2'b11, 6'h2A, 1'b0}), 68, 1'b0, D1};
        vecs[6] = '{1'b1, 1'b1, 14'h1234, D3, 1'b0, 1000, 64'h0, 17'd81, 81,
                    128'({2'b10, 14'h1234, D3, 1'b0}), 16, 1'b1, D1};
        vecs[7] = '{1'b0, 1'b1, 14'h0001, 64'h0, 1'b1, 0, D4, 17'd17, 17,
                    128'({2'b11, 14'h0001, 1'b0}), 68, 1'b0, D4};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset ready/rv/err/cs/valid/write/dout",
              128'({req_ready, resp_valid, resp_error, ee_cs, ee_valid, ee_write, ee_dout}),
              128'(7'b1000000));
        check("reset dma_eepromcount", 128'(dma_eepromcount), 128'(0));
        check("reset resp_rdata", 128'(resp_rdata), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
            $display("vector %0d: write=%0b model=%0b addr=%h wbits=%0d reads=%0d err=%0b rdata=%h",
                     i, vecs[i].wr, vecs[i].mdl, vecs[i].addr, wcount, rcount, resp_error, resp_rdata);
        end

        // Reset in the middle of the write-data phase
        @(negedge clk);
        stall      = 1'b0;
        cur_write  = 1'b1;
        poll_zeros = 0;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        model      = 1'b0;
        req_addr   = 14'h0015;
        req_wdata  = D3;
        @(negedge clk);
        req_valid = 1'b0;
        reached   = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (wcount >= 48) begin
                reached = 1'b1;
                break;
            end
        end
        check("mid-write reached data bit 40", 128'(reached), 128'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-write reset ready/rv/err/cs/valid/write/dout",
              128'({req_ready, resp_valid, resp_error, ee_cs, ee_valid, ee_write, ee_dout}),
              128'(7'b1000000));
        check("mid-write reset dma", 128'(dma_eepromcount), 128'(0));
        check("mid-write reset resp_rdata", 128'(resp_rdata), 128'(0));
        seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (resp_valid || ee_cs) seen = 1'b1;
        end
        check("no activity after abandon", 128'(seen), 128'(1'b0));
        $display("reset mid-write: abandoned after %0d write bits", wcount);
        run_vec(8, vecs[1]);
        $display("vector 8: read after reset wbits=%0d reads=%0d rdata=%h", wcount, rcount, resp_rdata);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
